// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - decode-stage register hazard scoreboard
// Tracks in-flight writes per register and in total; stalls ID on RAW hazards or full tracking.
module id_scoreboard #(
    parameter int NREG     = 32,
    parameter int CNT_W    = 2,
    parameter int MAX_INFL = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid,
    input  logic [4:0]                       id_rs1,
    input  logic [4:0]                       id_rs2,
    input  logic                             id_rs1_en,
    input  logic                             id_rs2_en,
    input  logic [4:0]                       id_rd,
    input  logic                             id_rf_we,
    output logic                             id_ready,
    input  logic                             wb_we,
    input  logic [4:0]                       wb_wR,
    input  logic                             kill_valid,
    input  logic [4:0]                       kill_wR,
    input  logic                             flush_all,
    output logic [$clog2(MAX_INFL+1)-1:0]    in_flight,
    output logic                             sb_busy,
    output logic                             sb_err
);

    localparam int TOT_W = $clog2(MAX_INFL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_INFL);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [CNT_W+1:0] cnt_sum [NREG];
    logic [TOT_W-1:0] tot;
    logic [TOT_W-1:0] tot_nxt;
    logic [TOT_W+1:0] tot_sum;
    logic             err;
    logic             under;

    logic raw;
    logic full;
    logic issue;
    logic wb_ev;
    logic kill_ev;

    // cnt[0] is held at zero, so x0 never reads as pending
    assign raw  = (id_rs1_en && cnt[id_rs1] != '0) || (id_rs2_en && cnt[id_rs2] != '0);
    assign full = id_rf_we && (id_rd != 5'd0) && (cnt[id_rd] == CNT_MAX || tot == TOT_MAX);
    assign id_ready = !raw && !full;

    assign issue   = id_valid && id_ready && id_rf_we && (id_rd != 5'd0);
    assign wb_ev   = wb_we && (wb_wR != 5'd0);
    assign kill_ev = kill_valid && (kill_wR != 5'd0);

    // Sums carry two extra bits: top bit flags underflow, next bit flags overflow
    always_comb begin
        under = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_sum[r] = {2'b00, cnt[r]}
                       + (CNT_W+2)'(issue   && id_rd   == 5'(r))
                       - (CNT_W+2)'(wb_ev   && wb_wR   == 5'(r))
                       - (CNT_W+2)'(kill_ev && kill_wR == 5'(r));
            cnt_nxt[r] = cnt_sum[r][CNT_W-1:0];
            if (r == 0) begin
                cnt_nxt[r] = '0;
            end else if (cnt_sum[r][CNT_W+1]) begin
                cnt_nxt[r] = '0;
                under      = 1'b1;
            end else if (cnt_sum[r][CNT_W]) begin
                cnt_nxt[r] = CNT_MAX;
            end
        end

        tot_sum = {2'b00, tot}
                + (TOT_W+2)'(issue)
                - (TOT_W+2)'(wb_ev)
                - (TOT_W+2)'(kill_ev);
        tot_nxt = tot_sum[TOT_W-1:0];
        if (tot_sum[TOT_W+1]) begin
            tot_nxt = '0;
            under   = 1'b1;
        end else if (tot_sum[TOT_W]) begin
            tot_nxt = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            tot <= '0;
            err <= 1'b0;
        end else if (flush_all) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            tot <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            tot <= tot_nxt;
            if (under) err <= 1'b1;
        end
    end

    assign in_flight = tot;
    assign sb_busy   = (tot != '0);
    assign sb_err    = err;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - self-checking bench for id_scoreboard
// Model of counters runs alongside; outputs compared every negedge plus literal spot checks.
module tb_id_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_en;
    logic       id_rs2_en;
    logic [4:0] id_rd;
    logic       id_rf_we;
    logic       id_ready;
    logic       wb_we;
    logic [4:0] wb_wR;
    logic       kill_valid;
    logic [4:0] kill_wR;
    logic       flush_all;
    logic [2:0] in_flight;
    logic       sb_busy;
    logic       sb_err;

    id_scoreboard #(.NREG(32), .CNT_W(2), .MAX_INFL(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_ready(id_ready),
        .wb_we(wb_we), .wb_wR(wb_wR),
        .kill_valid(kill_valid), .kill_wR(kill_wR),
        .flush_all(flush_all),
        .in_flight(in_flight), .sb_busy(sb_busy), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int m_cnt [32];
    int m_tot;
    bit m_err;
    int checks;
    int passes;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_ready();
        bit raw;
        bit full;
        raw  = (id_rs1_en && id_rs1 != 0 && m_cnt[id_rs1] != 0) ||
               (id_rs2_en && id_rs2 != 0 && m_cnt[id_rs2] != 0);
        full = id_rf_we && id_rd != 0 && (m_cnt[id_rd] == 3 || m_tot == 4);
        return !raw && !full;
    endfunction

    task automatic model_clear(input bit with_err);
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_tot = 0;
        if (with_err) m_err = 0;
    endtask

    // Advance one clock; model takes the edge from the inputs held during the cycle
    task automatic tick();
        int n [32];
        int nt;
        @(posedge clk);
        if (rst) begin
            model_clear(1'b1);
        end else if (flush_all) begin
            model_clear(1'b0);
        end else begin
            n  = m_cnt;
            nt = m_tot;
            if (id_valid && m_ready() && id_rf_we && id_rd != 0) begin n[id_rd]++; nt++; end
            if (wb_we && wb_wR != 0) begin n[wb_wR]--; nt--; end
            if (kill_valid && kill_wR != 0) begin n[kill_wR]--; nt--; end
            foreach (n[i]) if (n[i] < 0) begin n[i] = 0; m_err = 1; end
            if (nt < 0) begin nt = 0; m_err = 1; end
            m_cnt = n;
            m_tot = nt;
        end
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
        id_rd = 0; id_rf_we = 0; wb_we = 0; wb_wR = 0;
        kill_valid = 0; kill_wR = 0; flush_all = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd);
        id_valid = 1; id_rf_we = 1; id_rd = rd;
    endtask

    task automatic retire(input logic [4:0] r);
        clr(); wb_we = 1; wb_wR = r; tick();
    endtask

    always @(negedge clk) begin
        chk("ready", int'(id_ready), int'(m_ready()));
        chk("in_flight", int'(in_flight), m_tot);
        chk("busy", int'(sb_busy), int'(m_tot != 0));
        chk("err", int'(sb_err), int'(m_err));
    end

    initial begin
        checks = 0; passes = 0; m_err = 0;
        model_clear(1'b1);
        rst = 1; clr();
        tick(); tick();
        rst = 0;
        id_valid = 1; id_rs1 = 5; id_rs1_en = 1; id_rs2 = 9; id_rs2_en = 1;
        #1;
        chk("rst_ready", int'(id_ready), 1);
        chk("rst_in_flight", int'(in_flight), 0);
        chk("rst_err", int'(sb_err), 0);

        // RAW on x5, cleared by retire one cycle later
        clr(); set_issue(5); tick();
        clr(); id_valid = 1; id_rs1 = 5; id_rs1_en = 1; #1;
        chk("raw_stall", int'(id_ready), 0);
        chk("raw_in_flight", int'(in_flight), 1);
        wb_we = 1; wb_wR = 5; tick();
        wb_we = 0; #1;
        chk("raw_cleared", int'(id_ready), 1);
        chk("raw_drained", int'(in_flight), 0);
        tick();

        // x0 never counts or stalls
        clr(); set_issue(0); id_rs2 = 0; id_rs2_en = 1;
        repeat (3) tick();
        chk("x0_ready", int'(id_ready), 1);
        chk("x0_in_flight", int'(in_flight), 0);
        kill_valid = 1; kill_wR = 0; wb_we = 1; wb_wR = 0; tick();

        // per-register saturation on x7
        clr(); set_issue(7);
        repeat (3) tick();
        chk("full_reg", int'(id_ready), 0);
        chk("full_in_flight", int'(in_flight), 3);
        tick();
        wb_we = 1; wb_wR = 7; tick();
        wb_we = 0; #1;
        chk("full_reg_freed", int'(id_ready), 1);
        chk("full_reg_dec", int'(in_flight), 2);
        tick();
        chk("full_reg_again", int'(id_ready), 0);
        chk("full_reg_back", int'(in_flight), 3);
        repeat (3) retire(7);

        // total limit, with retire and kill together
        for (int i = 1; i <= 4; i++) begin clr(); set_issue(5'(i)); tick(); end
        clr(); set_issue(9); #1;
        chk("tot_full", int'(id_ready), 0);
        chk("tot_four", int'(in_flight), 4);
        wb_we = 1; wb_wR = 1; kill_valid = 1; kill_wR = 2; tick();
        wb_we = 0; kill_valid = 0; #1;
        chk("tot_two", int'(in_flight), 2);
        chk("tot_ready", int'(id_ready), 1);
        tick();
        chk("tot_three", int'(in_flight), 3);
        retire(3); retire(4); retire(9);

        // simultaneous issue and retire on x6
        clr(); set_issue(6); tick();
        wb_we = 1; wb_wR = 6; tick();
        chk("same_in_flight", int'(in_flight), 1);
        chk("same_err", int'(sb_err), 0);
        retire(6);

        // underflow is sticky
        retire(10);
        chk("under_err", int'(sb_err), 1);
        chk("under_cnt", int'(in_flight), 0);
        clr(); id_rs1 = 10; id_rs1_en = 1; #1;
        chk("under_no_stall", int'(id_ready), 1);
        tick(); tick();
        chk("err_sticky", int'(sb_err), 1);

        // flush with three pending, issue and read in the same cycle
        for (int i = 11; i <= 13; i++) begin clr(); set_issue(5'(i)); tick(); end
        clr(); flush_all = 1; set_issue(14); id_rs1 = 11; id_rs1_en = 1; #1;
        chk("flush_pre_ready", int'(id_ready), 0);
        tick();
        clr(); #1;
        chk("flush_in_flight", int'(in_flight), 0);
        chk("flush_busy", int'(sb_busy), 0);
        chk("flush_err_kept", int'(sb_err), 1);

        // mid-operation async reset
        set_issue(15); tick();
        clr(); rst = 1; model_clear(1'b1); #1;
        chk("rst_err_clr", int'(sb_err), 0);
        chk("rst_inflight_clr", int'(in_flight), 0);
        tick();
        rst = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
